// File: rtl/serial_pattern_source_if.sv
`default_nettype none
//============================================================================
// Module      : serial_pattern_source_if
// Description : Serial output bundle of serial_pattern_source. The master
//               (pattern source) drives the serial bit, its qualifiers and
//               the run/debug status. The slave (for example a downstream
//               sequence detector) only observes these signals.
// Revision    : 1.0 - initial release
//============================================================================
interface serial_pattern_source_if;
    logic       data_out;
    logic       data_valid;
    logic       bit_strobe;
    logic       busy;
    logic       done;
    logic [1:0] state_out;

    modport master (
        output data_out,
        output data_valid,
        output bit_strobe,
        output busy,
        output done,
        output state_out
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  bit_strobe,
        input  busy,
        input  done,
        input  state_out
    );
endinterface
`default_nettype wire

// File: rtl/serial_pattern_source.sv
`default_nettype none
//============================================================================
// Module      : serial_pattern_source
// Description : Push-button triggered serial pattern generator. A
//               debounced press of go_btn loads pattern_in and shifts it
//               out MSB first, one bit every TICK_DIV clocks, followed by a
//               one-cycle done pulse.
// Revision    : 1.0 - initial release
//============================================================================
module serial_pattern_source #(
    parameter int WIDTH           = 8,
    parameter int TICK_DIV        = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             go_btn,
    input  wire logic [WIDTH-1:0] pattern_in,
    serial_pattern_source_if.master o_ser
);

    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int c_BIT_W  = $clog2(WIDTH + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_BIT_W-1:0]  c_BITS      = c_BIT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [1:0]            r_sync;
    logic [1:0]            r_fill;
    logic                  r_db_level;
    logic [c_DB_W-1:0]     r_db_cnt;
    logic                  r_db_prev;
    logic [c_DB_W-1:0]     r_rel_cnt;
    logic                  r_armed;
    logic                  w_go_pulse;

    logic [c_TICK_W-1:0]   r_tick;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [WIDTH-1:0]      r_shift;
    logic                  w_tick_last;

    // Two-flop synchronizer for the raw button; r_fill marks when the
    // synchronizer output reflects the real pin rather than its reset value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b00;
            r_fill <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], go_btn};
            r_fill <= {r_fill[0], 1'b1};
        end
    end

    // Debouncer: the level flips only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
        end else if (r_sync[1] == r_db_level) begin
            r_db_cnt   <= '0;
        end else if (r_db_cnt == c_DB_LAST) begin
            r_db_level <= ~r_db_level;
            r_db_cnt   <= '0;
        end else begin
            r_db_cnt   <= r_db_cnt + c_DB_W'(1);
        end
    end

    // Edge detect plus arming: after reset a press is only honoured once the
    // button has been seen released for a full debounce period, so a button
    // held through reset release never starts a run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db_prev <= 1'b0;
            r_rel_cnt <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_db_prev <= r_db_level;
            if (!r_fill[1] || r_sync[1]) begin
                r_rel_cnt <= '0;
            end else if (r_rel_cnt == c_DB_LAST) begin
                r_armed   <= 1'b1;
            end else begin
                r_rel_cnt <= r_rel_cnt + c_DB_W'(1);
            end
        end
    end

    assign w_go_pulse  = r_db_level & ~r_db_prev & r_armed;
    assign w_tick_last = (r_tick == c_TICK_LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; go_pulse outside IDLE is simply dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_go_pulse) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_tick_last && (r_bit_cnt == c_BIT_W'(1))) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: pattern capture in LOAD, bit timing and shifting in SHIFT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_shift   <= pattern_in;
                    r_tick    <= '0;
                    r_bit_cnt <= c_BITS;
                end
                S_SHIFT: begin
                    if (w_tick_last) begin
                        r_tick    <= '0;
                        r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt - c_BIT_W'(1);
                    end else begin
                        r_tick    <= r_tick + c_TICK_W'(1);
                    end
                end
                default: begin
                    r_tick    <= r_tick;
                    r_bit_cnt <= r_bit_cnt;
                    r_shift   <= r_shift;
                end
            endcase
        end
    end

    // Outputs are decoded purely from registered state.
    assign o_ser.data_out   = (r_state == S_SHIFT) & r_shift[WIDTH-1];
    assign o_ser.data_valid = (r_state == S_SHIFT);
    assign o_ser.bit_strobe = (r_state == S_SHIFT) & (r_tick == '0);
    assign o_ser.busy       = (r_state != S_IDLE);
    assign o_ser.done       = (r_state == S_DONE);
    assign o_ser.state_out  = r_state;

endmodule
`default_nettype wire
